step_control: RTL and testbench
===============================

STEP_CONTROL -- requirements
Module: step_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, stable cycles needed before a key level change is accepted (10 ms at 50 MHz).
REQ-002 Parameter RUN_DIV, default 5000000, clock cycles per cpu_enable pulse in run mode (10 Hz at 50 MHz).
REQ-003 clock  input  1  system clock; all state rising-edge triggered.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 step_key  input  1  raw pushbutton, active-low, asynchronous to clock.
REQ-006 run_mode  input  1  level from a switch: 1 selects free-run, 0 selects single-step.
REQ-007 halt  input  1  synchronous stop request from the processor.
REQ-008 cpu_enable  output  1  registered one-cycle clock-enable pulse to the processor.
REQ-009 step_count  output  32  number of cpu_enable pulses issued since reset.
REQ-010 state  output  2  current FSM state: IDLE=00, STEP=01, RUN=10, HALTED=11.

Function
REQ-011 step_key SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Debounced level SHALL update only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count at 0.
REQ-013 A press is a debounced 1->0 transition; it is detected in the cycle the debounced level changes.
REQ-014 IDLE: press -> STEP; run_mode=1 -> RUN. If both occur, RUN wins and the press is dropped.
REQ-015 STEP: cpu_enable=1 for exactly the one cycle spent in STEP; next state IDLE. Latency: cpu_enable high the cycle after press detection.
REQ-016 RUN: divider counts 0..RUN_DIV-1 and wraps to 0; cpu_enable=1 in the cycle after the divider reaches RUN_DIV-1. Presses are ignored.
REQ-017 RUN with run_mode=0 -> IDLE; the divider clears to 0 and no further pulse is issued.
REQ-018 halt=1 in any state -> HALTED next cycle; a cpu_enable pulse scheduled for that next cycle is suppressed.
REQ-019 HALTED: cpu_enable=0; presses ignored; exits to IDLE only when halt=0 and run_mode=0 in the same cycle.
REQ-020 step_count SHALL increment by 1 in each cycle cpu_enable=1 and wrap from 0xFFFFFFFF to 0.
REQ-021 cpu_enable SHALL never be high for two consecutive cycles when RUN_DIV>=2.

Reset
REQ-022 While reset=0: state=IDLE, cpu_enable=0, step_count=0, divider=0, debounce counter=0, synchronizer flops and debounced level=1 (released).
REQ-023 Reset assertion mid-pulse SHALL clear cpu_enable immediately (asynchronous); after release, a key still held SHALL NOT register as a press.

Configuration
REQ-024 Macro STEP_BREAKPOINT_EN adds inputs pc (32), break_addr (32) and break_valid (1).
REQ-025 With STEP_BREAKPOINT_EN defined: in RUN or STEP, when break_valid=1 and pc==break_addr, the next state is HALTED and any pulse due in that next cycle is suppressed, exactly as for halt.
REQ-026 With STEP_BREAKPOINT_EN undefined: these ports and the comparison logic are absent; behaviour matches REQ-011..REQ-023 exactly.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=3 unless stated)
REQ-027 Hold step_key=0 for 10 cycles, then release -> exactly one cpu_enable pulse; step_count=1; state returns to 00.
REQ-028 Toggle step_key with pulses of 2 cycles low / 2 cycles high for 20 cycles -> no cpu_enable; step_count=0.
REQ-029 Set run_mode=1 for 30 cycles -> cpu_enable high every 3rd cycle; step_count=10 (+/-1 at the window edges); state=10.
REQ-030 In RUN, raise halt the cycle before a pulse is due -> no pulse; state=11. Set halt=0 and run_mode=0 -> state=00 next cycle.
REQ-031 Force step_count to 0xFFFFFFFF, then issue one step -> step_count=0x00000000.
REQ-032 With STEP_BREAKPOINT_EN defined: break_addr=0x10, break_valid=1, run with pc stepping 0x0C, 0x10 -> state=11 and no pulse after pc=0x10.

Source files
------------

// File: rtl/step_control.sv
// Processor step/run clock-enable controller with debounced step key.
// Optional breakpoint compare is enabled with macro STEP_BREAKPOINT_EN.
module step_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step_key,
  input  logic        run_mode,
  input  logic        halt,
`ifdef STEP_BREAKPOINT_EN
  input  logic [31:0] pc,
  input  logic [31:0] break_addr,
  input  logic        break_valid,
`endif
  output logic        cpu_enable,
  output logic [31:0] step_count,
  output logic [1:0]  state
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STEP   = 2'b01,
    RUN    = 2'b10,
    HALTED = 2'b11
  } state_t;

  logic [1:0]       sync_q;
  logic [1:0]       valid_q;
  logic             armed_q;
  logic             key_level_q;
  logic             key_prev_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_next;
  logic [31:0]      count_q;
  state_t           state_q;
  state_t           state_next;
  logic             pulse_next;
  logic             press_c;
  logic             bp_hit_c;

  // Synchronize and debounce the key; armed_q blocks a press from a key held through reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q      <= 2'b11;
      valid_q     <= 2'b00;
      armed_q     <= 1'b0;
      key_level_q <= 1'b1;
      key_prev_q  <= 1'b1;
      db_cnt_q    <= '0;
    end else begin
      sync_q     <= {sync_q[0], step_key};
      valid_q    <= {valid_q[0], 1'b1};
      key_prev_q <= key_level_q;
      if (valid_q[1] && sync_q[1] && key_level_q) begin
        armed_q <= 1'b1;
      end
      if (sync_q[1] != key_level_q) begin
        if (db_cnt_q == DB_LAST) begin
          key_level_q <= sync_q[1];
          db_cnt_q    <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign press_c = armed_q & key_prev_q & ~key_level_q;

`ifdef STEP_BREAKPOINT_EN
  assign bp_hit_c = break_valid && (pc == break_addr) &&
                    ((state_q == RUN) || (state_q == STEP));
`else
  assign bp_hit_c = 1'b0;
`endif

  // Next-state, divider and pulse scheduling; a stop request overrides everything.
  always_comb begin
    state_next = state_q;
    div_next   = div_q;
    pulse_next = 1'b0;
    case (state_q)
      IDLE: begin
        div_next = '0;
        if (run_mode) begin
          state_next = RUN;
        end else if (press_c) begin
          state_next = STEP;
          pulse_next = 1'b1;
        end
      end
      STEP: begin
        div_next   = '0;
        state_next = IDLE;
      end
      RUN: begin
        if (!run_mode) begin
          state_next = IDLE;
          div_next   = '0;
        end else if (div_q == DIV_LAST) begin
          div_next   = '0;
          pulse_next = 1'b1;
        end else begin
          div_next = div_q + DIV_W'(1);
        end
      end
      HALTED: begin
        div_next = '0;
        if (!halt && !run_mode) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        div_next   = '0;
      end
    endcase
    if (halt || bp_hit_c) begin
      state_next = HALTED;
      pulse_next = 1'b0;
      div_next   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cpu_enable <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_next;
      div_q      <= div_next;
      cpu_enable <= pulse_next;
      count_q    <= count_q + 32'(cpu_enable);
    end
  end

  assign step_count = count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_step_control.sv
// Directed bench for step_control (DEBOUNCE_CYCLES=4, RUN_DIV=3).
// Breakpoint scenario is included when STEP_BREAKPOINT_EN is defined.
module tb_step_control;

  logic        clock;
  logic        reset;
  logic        step_key;
  logic        run_mode;
  logic        halt;
  logic        cpu_enable;
  logic [31:0] step_count;
  logic [1:0]  state;
`ifdef STEP_BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] break_addr;
  logic        break_valid;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  logic prev_en = 1'b0;
  logic b2b     = 1'b0;
  int p0;

  step_control #(
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .step_key  (step_key),
    .run_mode  (run_mode),
    .halt      (halt),
`ifdef STEP_BREAKPOINT_EN
    .pc        (pc),
    .break_addr(break_addr),
    .break_valid(break_valid),
`endif
    .cpu_enable(cpu_enable),
    .step_count(step_count),
    .state     (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count pulses of the cycle that just ended and flag back-to-back pulses.
  always @(posedge clock) begin
    if (cpu_enable) pulses = pulses + 1;
    if (cpu_enable && prev_en) b2b = 1'b1;
    prev_en = cpu_enable;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_release();
    step_key = 1'b0;
    cycles(10);
    step_key = 1'b1;
    cycles(10);
  endtask

  initial begin
    reset    = 1'b0;
    step_key = 1'b1;
    run_mode = 1'b0;
    halt     = 1'b0;
`ifdef STEP_BREAKPOINT_EN
    pc          = 32'h0;
    break_addr  = 32'h0;
    break_valid = 1'b0;
`endif
    cycles(3);
    check("reset_state", 32'(state), 32'd0);
    check("reset_en", 32'(cpu_enable), 32'd0);
    check("reset_count", step_count, 32'd0);
    reset = 1'b1;
    cycles(5);

    // Bouncing key: 2 low / 2 high never survives the debounce window.
    p0 = pulses;
    for (int r = 0; r < 5; r++) begin
      step_key = 1'b0;
      cycles(2);
      step_key = 1'b1;
      cycles(2);
    end
    cycles(8);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);
    check("glitch_count", step_count, 32'd0);

    // Single step: sync (2) + debounce (4) + edge detect -> pulse on the 7th edge.
    p0 = pulses;
    step_key = 1'b0;
    cycles(6);
    check("step_early", 32'(cpu_enable), 32'd0);
    cycles(1);
    check("step_pulse", 32'(cpu_enable), 32'd1);
    check("step_state", 32'(state), 32'd1);
    cycles(1);
    check("step_after_en", 32'(cpu_enable), 32'd0);
    check("step_after_state", 32'(state), 32'd0);
    check("step_count1", step_count, 32'd1);
    cycles(2);
    step_key = 1'b1;
    cycles(10);
    check("step_pulses", 32'(pulses - p0), 32'd1);
    check("step_idle", 32'(state), 32'd0);

    // Free run for 30 cycles: pulses on edges 4, 7, ..., 28.
    p0 = pulses;
    run_mode = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      cycles(1);
      check("run_pulse", 32'(cpu_enable), ((i >= 4) && (i % 3 == 1)) ? 32'd1 : 32'd0);
    end
    check("run_state", 32'(state), 32'd2);
    run_mode = 1'b0;
    cycles(1);
    check("run_exit_state", 32'(state), 32'd0);
    check("run_exit_en", 32'(cpu_enable), 32'd0);
    cycles(3);
    check("run_pulses", 32'(pulses - p0), 32'd9);
    check("run_count", step_count, 32'd10);

    // Halt raised the cycle before a pulse is due.
    run_mode = 1'b1;
    cycles(3);
    check("halt_pre_en", 32'(cpu_enable), 32'd0);
    halt = 1'b1;
    cycles(1);
    check("halt_en", 32'(cpu_enable), 32'd0);
    check("halt_state", 32'(state), 32'd3);
    cycles(2);
    check("halt_hold", 32'(state), 32'd3);
    halt = 1'b0;
    cycles(1);
    check("halt_run_stays", 32'(state), 32'd3);
    run_mode = 1'b0;
    cycles(1);
    check("halt_exit", 32'(state), 32'd0);
    check("halt_count", step_count, 32'd10);

    // Counter wrap.
    dut.count_q = 32'hFFFF_FFFF;
    cycles(1);
    check("wrap_preset", step_count, 32'hFFFF_FFFF);
    press_release();
    check("wrap_count", step_count, 32'h0000_0000);

    // Asynchronous reset mid-pulse with the key still held afterwards.
    step_key = 1'b0;
    cycles(7);
    check("pre_reset_pulse", 32'(cpu_enable), 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_en", 32'(cpu_enable), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_count", step_count, 32'd0);
    cycles(2);
    reset = 1'b1;
    p0 = pulses;
    cycles(15);
    check("held_key_pulses", 32'(pulses - p0), 32'd0);
    step_key = 1'b1;
    cycles(10);
    check("held_key_count", step_count, 32'd0);
    press_release();
    check("rearm_count", step_count, 32'd1);

`ifdef STEP_BREAKPOINT_EN
    // Breakpoint at 0x10 while running.
    break_addr  = 32'h10;
    break_valid = 1'b1;
    pc          = 32'h0C;
    run_mode    = 1'b1;
    cycles(4);
    check("bp_pre_state", 32'(state), 32'd2);
    pc = 32'h10;
    cycles(1);
    check("bp_state", 32'(state), 32'd3);
    check("bp_en", 32'(cpu_enable), 32'd0);
    p0 = pulses;
    cycles(5);
    check("bp_no_pulse", 32'(pulses - p0), 32'd0);
    check("bp_hold", 32'(state), 32'd3);
    break_valid = 1'b0;
    run_mode    = 1'b0;
    cycles(1);
    check("bp_exit", 32'(state), 32'd0);
`endif

    check("no_back_to_back", 32'(b2b), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
